// File: rtl/gfx128_pkg.sv
// Shared types and bus constants for the gfx128 Wishbone master blocks.
package gfx128_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        HOLD = 2'd2
    } wbm_rw_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/gfx128_wbm_readwrite.sv
// Single-beat 128-bit Wishbone classic master: latches one arbiter request,
// runs the bus cycle with an optional timeout, then pulses ack_o for one cycle.
module gfx128_wbm_readwrite
    import gfx128_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         read_request_i,
    input  logic         write_request_i,
    input  logic [31:4]  addr_i,
    input  logic         we_i,
    input  logic [15:0]  sel_i,
    input  logic [127:0] dat_i,
    output logic [127:0] dat_o,
    output logic         ack_o,
    output logic         wbm_cyc_o,
    output logic         wbm_stb_o,
    output logic [2:0]   wbm_cti_o,
    output logic [1:0]   wbm_bte_o,
    output logic         wbm_we_o,
    output logic [31:0]  wbm_adr_o,
    output logic [15:0]  wbm_sel_o,
    output logic [127:0] wbm_dat_o,
    input  logic [127:0] wbm_dat_i,
    input  logic         wbm_ack_i,
    input  logic         wbm_err_i,
    output logic         busy_o,
    output logic         err_o,
    input  logic         err_clr_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    wbm_rw_state_t state;
    logic [31:4]   addr_q;
    logic [15:0]   sel_q;
    logic [127:0]  dat_q;
    logic          we_q;
    logic          is_write_q;
    logic [CNT_W-1:0] cnt;

    logic in_bus;
    logic timeout_hit;
    logic bus_fail;

    assign in_bus      = (state == BUS);
    // An ack in the final allowed cycle still completes normally.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
    assign bus_fail    = wbm_err_i || (timeout_hit && !wbm_ack_i);

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst_i) begin
            state      <= IDLE;
            addr_q     <= '0;
            sel_q      <= '0;
            dat_q      <= '0;
            we_q       <= 1'b0;
            is_write_q <= 1'b0;
            cnt        <= '0;
            dat_o      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (read_request_i || write_request_i) begin
                        addr_q     <= addr_i;
                        sel_q      <= sel_i;
                        dat_q      <= dat_i;
                        we_q       <= we_i;
                        is_write_q <= write_request_i;
                        cnt        <= '0;
                        state      <= BUS;
                    end
                end
                BUS: begin
                    cnt <= cnt + 1'b1;
                    if (bus_fail) begin
                        dat_o <= '0;
                        state <= HOLD;
                    end else if (wbm_ack_i) begin
                        if (!is_write_q) begin
                            dat_o <= wbm_dat_i;
                        end
                        state <= HOLD;
                    end
                end
                HOLD:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky error flag; a new failure outranks a coincident clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (in_bus && bus_fail) begin
            err_o <= 1'b1;
        end else if (err_clr_i) begin
            err_o <= 1'b0;
        end
    end

    assign wbm_cyc_o = in_bus;
    assign wbm_stb_o = in_bus;
    assign wbm_we_o  = in_bus && is_write_q && we_q;
    assign wbm_adr_o = {addr_q, 4'h0};
    assign wbm_sel_o = sel_q;
    assign wbm_dat_o = dat_q;
    assign wbm_cti_o = CTI_CLASSIC;
    assign wbm_bte_o = BTE_LINEAR;
    assign ack_o     = (state == HOLD);
    assign busy_o    = (state != IDLE);

endmodule

// File: tb/tb_gfx128_wbm_readwrite.sv
// Table-driven bench for gfx128_wbm_readwrite with a scripted Wishbone slave.
module tb_gfx128_wbm_readwrite;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         read_request_i, write_request_i, we_i;
    logic [31:4]  addr_i;
    logic [15:0]  sel_i;
    logic [127:0] dat_i;
    logic [127:0] dat_o;
    logic         ack_o;
    logic         wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [2:0]   wbm_cti_o;
    logic [1:0]   wbm_bte_o;
    logic [31:0]  wbm_adr_o;
    logic [15:0]  wbm_sel_o;
    logic [127:0] wbm_dat_o;
    logic [127:0] wbm_dat_i;
    logic         wbm_ack_i, wbm_err_i;
    logic         busy_o, err_o, err_clr_i;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] RSP_ACK  = 2'd0;
    localparam logic [1:0] RSP_ERR  = 2'd1;
    localparam logic [1:0] RSP_BOTH = 2'd2;
    localparam logic [1:0] RSP_NONE = 2'd3;

    typedef struct {
        logic         rd;
        logic         wr;
        logic         we;
        logic [27:0]  addr;
        logic [15:0]  sel;
        logic [127:0] dat;
        int           wait_cyc;
        logic [1:0]   rsp;
        logic [127:0] slv_dat;
        logic [31:0]  exp_adr;
        logic         exp_we;
        logic [127:0] exp_dat_o;
        logic         exp_err;
        int           exp_bus;
    } vec_t;

    vec_t vecs[7];

    gfx128_wbm_readwrite #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .read_request_i  (read_request_i),
        .write_request_i (write_request_i),
        .addr_i          (addr_i),
        .we_i            (we_i),
        .sel_i           (sel_i),
        .dat_i           (dat_i),
        .dat_o           (dat_o),
        .ack_o           (ack_o),
        .wbm_cyc_o       (wbm_cyc_o),
        .wbm_stb_o       (wbm_stb_o),
        .wbm_cti_o       (wbm_cti_o),
        .wbm_bte_o       (wbm_bte_o),
        .wbm_we_o        (wbm_we_o),
        .wbm_adr_o       (wbm_adr_o),
        .wbm_sel_o       (wbm_sel_o),
        .wbm_dat_o       (wbm_dat_o),
        .wbm_dat_i       (wbm_dat_i),
        .wbm_ack_i       (wbm_ack_i),
        .wbm_err_i       (wbm_err_i),
        .busy_o          (busy_o),
        .err_o           (err_o),
        .err_clr_i       (err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   bus_cyc;
        bit   done;
        v       = vecs[idx];
        bus_cyc = 0;
        done    = 1'b0;
        @(negedge clk_i);
        read_request_i  = v.rd;
        write_request_i = v.wr;
        we_i            = v.we;
        addr_i          = v.addr;
        sel_i           = v.sel;
        dat_i           = v.dat;
        wbm_ack_i       = 1'b0;
        wbm_err_i       = 1'b0;
        @(negedge clk_i);
        // Scramble the request side: the latched values must govern the cycle.
        read_request_i  = 1'b0;
        write_request_i = 1'b0;
        we_i            = ~v.we;
        addr_i          = ~v.addr;
        sel_i           = ~v.sel;
        dat_i           = ~v.dat;
        for (int k = 0; k < 40 && !done; k++) begin
            if (k > 0) begin
                @(negedge clk_i);
                wbm_ack_i = 1'b0;
                wbm_err_i = 1'b0;
            end
            if (wbm_cyc_o) begin
                bus_cyc++;
                if (k == 0) begin
                    check($sformatf("v%0d stb", idx), 128'(wbm_stb_o), 128'(1'b1));
                    check($sformatf("v%0d adr", idx), 128'(wbm_adr_o), 128'(v.exp_adr));
                    check($sformatf("v%0d we", idx), 128'(wbm_we_o), 128'(v.exp_we));
                    check($sformatf("v%0d sel", idx), 128'(wbm_sel_o), 128'(v.sel));
                    check($sformatf("v%0d wdat", idx), wbm_dat_o, v.dat);
                    check($sformatf("v%0d cti_bte", idx), 128'({wbm_cti_o, wbm_bte_o}), 128'(5'b0));
                end
                if (k == v.wait_cyc && v.rsp != RSP_NONE) begin
                    wbm_ack_i = (v.rsp == RSP_ACK) || (v.rsp == RSP_BOTH);
                    wbm_err_i = (v.rsp == RSP_ERR) || (v.rsp == RSP_BOTH);
                    wbm_dat_i = v.slv_dat;
                end
            end else begin
                done = 1'b1;
                check($sformatf("v%0d ack_o", idx), 128'(ack_o), 128'(1'b1));
                check($sformatf("v%0d busy_hold", idx), 128'(busy_o), 128'(1'b1));
                check($sformatf("v%0d dat_o", idx), dat_o, v.exp_dat_o);
                check($sformatf("v%0d err_o", idx), 128'(err_o), 128'(v.exp_err));
                check($sformatf("v%0d bus_cycles", idx), 128'(bus_cyc), 128'(v.exp_bus));
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL v%0d done: got no completion within 40 cycles, expected ack_o", idx);
        end
        @(negedge clk_i);
        check($sformatf("v%0d ack_pulse", idx), 128'(ack_o), 128'(1'b0));
        check($sformatf("v%0d busy_idle", idx), 128'(busy_o), 128'(1'b0));
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 28'h0000123, 16'hFFFF, 128'h0, 3, RSP_ACK,
                    {16{8'hA5}}, 32'h00001230, 1'b0, {16{8'hA5}}, 1'b0, 4};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 28'h0ABCDEF, 16'h000F, 128'h1, 1, RSP_ACK,
                    128'hDEAD, 32'h0ABCDEF0, 1'b1, {16{8'hA5}}, 1'b0, 2};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 28'hFFFFFFF, 16'h8001, 128'h1234_5678, 0, RSP_ACK,
                    {16{8'h55}}, 32'hFFFFFFF0, 1'b1, {16{8'hA5}}, 1'b0, 1};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 28'h0000000, 16'h00F0, 128'h77, 0, RSP_ACK,
                    128'h99, 32'h00000000, 1'b0, {16{8'hA5}}, 1'b0, 1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 28'h8000000, 16'h0FF0, 128'h0, 0, RSP_ACK,
                    128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 32'h80000000, 1'b0,
                    128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0, 1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 28'h0000456, 16'hFFFF, 128'h0, 2, RSP_BOTH,
                    {16{8'hFF}}, 32'h00004560, 1'b0, 128'h0, 1'b1, 3};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 28'h0000789, 16'hFFFF, 128'h0, 0, RSP_NONE,
                    128'h0, 32'h00007890, 1'b0, 128'h0, 1'b1, 8};

        rst_i           = 1'b1;
        read_request_i  = 1'b0;
        write_request_i = 1'b0;
        we_i            = 1'b0;
        addr_i          = '0;
        sel_i           = '0;
        dat_i           = '0;
        wbm_dat_i       = '0;
        wbm_ack_i       = 1'b0;
        wbm_err_i       = 1'b0;
        err_clr_i       = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst cyc", 128'(wbm_cyc_o), 128'(1'b0));
        check("rst ack", 128'(ack_o), 128'(1'b0));
        check("rst busy", 128'(busy_o), 128'(1'b0));
        check("rst err", 128'(err_o), 128'(1'b0));
        check("rst dat_o", dat_o, 128'h0);
        check("rst adr", 128'(wbm_adr_o), 128'h0);
        rst_i = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_vec(i);
        end

        // Sticky error survives idle cycles, then clears one cycle after err_clr_i.
        @(negedge clk_i);
        check("err sticky", 128'(err_o), 128'(1'b1));
        err_clr_i = 1'b1;
        @(negedge clk_i);
        err_clr_i = 1'b0;
        check("err cleared", 128'(err_o), 128'(1'b0));

        // Reset while the bus cycle is open abandons it without ack_o.
        read_request_i = 1'b1;
        addr_i         = 28'h0000ABC;
        @(negedge clk_i);
        read_request_i = 1'b0;
        check("mid cyc", 128'(wbm_cyc_o), 128'(1'b1));
        rst_i = 1'b1;
        @(negedge clk_i);
        check("mid rst cyc", 128'(wbm_cyc_o), 128'(1'b0));
        check("mid rst busy", 128'(busy_o), 128'(1'b0));
        check("mid rst ack", 128'(ack_o), 128'(1'b0));
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post rst ack", 128'(ack_o), 128'(1'b0));
        check("post rst busy", 128'(busy_o), 128'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gfx128_wbm_readwrite.md
GFX128_WBM_READWRITE -- requirements
Module: gfx128_wbm_readwrite

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: bus-cycle abort limit in clocks; 0 disables the timeout.
REQ-002 clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-003 rst_i  in  1  synchronous, active-high reset.
REQ-004 read_request_i  in  1  read request from the arbiter.
REQ-005 write_request_i  in  1  write request from the arbiter.
REQ-006 addr_i  in  [31:4]  128-bit-aligned word address.
REQ-007 we_i  in  1  write enable from the arbiter.
REQ-008 sel_i  in  16  byte lane select.
REQ-009 dat_i  in  128  write data.
REQ-010 dat_o  out  128  registered read data.
REQ-011 ack_o  out  1  one-cycle completion pulse to the arbiter.
REQ-012 Wishbone master outputs:
- wbm_cyc_o 1
- wbm_stb_o 1
- wbm_cti_o 3
- wbm_bte_o 2
- wbm_we_o 1
- wbm_adr_o 32
- wbm_sel_o 16
- wbm_dat_o 128
REQ-013 Wishbone master inputs: wbm_dat_i 128, wbm_ack_i 1, wbm_err_i 1.
REQ-014 busy_o  out  1  high whenever the block is not in IDLE.
REQ-015 err_o  out  1  sticky bus-error/timeout flag.
REQ-016 err_clr_i  in  1  clears err_o.

Function
REQ-017 The block SHALL implement FSM states IDLE, BUS and HOLD.
REQ-018 IDLE -> BUS when read_request_i or write_request_i is high. On that edge the block SHALL latch:
- addr_i, sel_i and dat_i;
- the operation type: write if write_request_i is high (write wins if both requests are high), else read.
REQ-019 In BUS, the Wishbone outputs SHALL be driven as follows:
- wbm_cyc_o = wbm_stb_o = 1;
- wbm_adr_o = {latched addr, 4'h0};
- wbm_sel_o = latched sel;
- wbm_dat_o = latched data;
- wbm_we_o = 1 only for a write whose latched we_i is 1;
- wbm_cti_o = 3'b000, wbm_bte_o = 2'b00.
REQ-020 Outside BUS, wbm_cyc_o, wbm_stb_o and wbm_we_o SHALL be 0.
REQ-021 BUS -> HOLD on wbm_ack_i. The same edge SHALL drop cyc/stb and, for a read, register wbm_dat_i into dat_o.
REQ-022 BUS -> HOLD on wbm_err_i: err_o SHALL be set and dat_o SHALL be set to 0. If wbm_err_i and wbm_ack_i are high together, err_i wins.
REQ-023 The timeout counter SHALL clear on entry to BUS and increment each cycle in BUS. When it reaches TIMEOUT_CYCLES-1 without ack/err, the block SHALL act as REQ-022. If ack arrives in the same cycle, ack wins.
REQ-024 ack_o SHALL be high exactly during the single HOLD cycle; HOLD -> IDLE unconditionally.
REQ-025 Minimum latency: request seen in IDLE at cycle 0, wbm_ack_i at cycle 1, ack_o at cycle 2. Back-to-back transactions SHALL have 1 idle cycle between them.
REQ-026 Requesters SHALL deassert or re-present their request in the cycle after ack_o. The block SHALL NOT sample requests in HOLD.
REQ-027 Request changes while in BUS or HOLD SHALL be ignored; the latched values govern the transaction.
REQ-028 err_o SHALL remain set until err_clr_i is high. If err_clr_i coincides with a new error, set wins.
REQ-029 dat_o SHALL hold its value until the next read completes.

Reset
REQ-030 On rst_i high at a clock edge, the block SHALL enter IDLE. This applies mid-transaction (abandon the bus cycle without ack_o).
REQ-031 Reset values: all outputs 0, counter 0.

Structure
REQ-032 gfx128_pkg SHALL hold the state enum typedef wbm_rw_state_t and the constants CTI_CLASSIC = 3'b000 and BTE_LINEAR = 2'b00.
REQ-033 No sub-module; FSM, latches and timeout counter SHALL be in one module.

Verification
REQ-034 Read:
- stimulus: read_request_i=1, addr_i=28'h0000123, sel_i=16'hFFFF; slave acks after 3 wait cycles with wbm_dat_i=128'hA5...A5;
- response: wbm_adr_o=32'h00001230, wbm_we_o=0, dat_o=128'hA5...A5, ack_o a single pulse.
REQ-035 Write:
- stimulus: write_request_i=1, we_i=1, sel_i=16'h000F, dat_i=128'h1;
- response: wbm_we_o=1, wbm_sel_o=16'h000F, wbm_dat_o=128'h1; inputs changed mid-BUS do not alter the wbm_* outputs.
REQ-036 Error: wbm_err_i=1 and wbm_ack_i=1 together -> err_o=1, dat_o=0, ack_o pulse; err_clr_i=1 -> err_o=0 next cycle.
REQ-037 Timeout: TIMEOUT_CYCLES=8, slave silent -> cyc drops after 8 BUS cycles, err_o=1, ack_o pulse.
REQ-038 Reset mid-BUS: rst_i=1 -> next edge wbm_cyc_o=0 and busy_o=0, with no ack_o.
REQ-039 Simultaneous read and write requests -> the write is performed.
